// File: rtl/sng_array.sv
// Multi-channel stochastic number generator: each channel turns a BW-bit value into a
// 2^BW-cycle unary-weighted bit stream. Optional macro SNG_DECOR_EN adds a per-channel phase offset.
module sng_array #(
  parameter int BW     = 4,
  parameter int NCH    = 4,
  parameter int STRIDE = 4
) (
  input  logic              i_clk_sng,
  input  logic              i_rst_sng,
  input  logic [NCH*BW-1:0] i_x_bn,
  input  logic              i_start_sng,
  input  logic              i_stop_sng,
  output logic [NCH-1:0]    o_sn_bit,
  output logic              o_sn_valid,
  output logic              o_busy,
  output logic              o_done
);

  // state | meaning
  // IDLE  | waiting for start; all outputs low
  // RUN   | emitting one stream bit per channel per cycle, cnt = current bit index
  // DONE  | one-cycle o_done pulse after the last bit of a complete stream

`ifdef SNG_DECOR_EN
  localparam int DECOR = 1;
`else
  localparam int DECOR = 0;
`endif

  localparam logic [BW-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [BW-1:0]     cnt;
  logic [BW-1:0]     cnt_nxt;
  logic [NCH*BW-1:0] x_lat;
  logic [NCH*BW-1:0] x_src;
  logic [NCH-1:0]    bit_nxt;
  logic [BW-1:0]     phase   [NCH];
  logic [BW-1:0]     rnd     [NCH];

  function automatic logic [BW-1:0] bit_rev(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < BW; i++) begin
      r[i] = v[BW-1-i];
    end
    return r;
  endfunction

  // Bits are produced one cycle ahead so o_sn_bit can be a plain register:
  // the entering edge of RUN emits index 0 straight from i_x_bn.
  always_comb begin
    cnt_nxt = (state == RUN) ? cnt + BW'(1) : '0;
    x_src   = (state == RUN) ? x_lat : i_x_bn;
    bit_nxt = '0;
    for (int k = 0; k < NCH; k++) begin
      // bit reversal is a permutation of 0..L-1, so any offset keeps ones counts exact
      phase[k]   = BW'(k * STRIDE * DECOR);
      rnd[k]     = bit_rev(cnt_nxt + phase[k]);
      bit_nxt[k] = (rnd[k] < x_src[k*BW +: BW]);
    end
  end

  always_ff @(posedge i_clk_sng or negedge i_rst_sng) begin
    if (!i_rst_sng) begin
      state      <= IDLE;
      cnt        <= '0;
      x_lat      <= '0;
      o_sn_bit   <= '0;
      o_sn_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start_sng && !i_stop_sng) begin
            state      <= RUN;
            x_lat      <= i_x_bn;
            cnt        <= '0;
            o_sn_bit   <= bit_nxt;
            o_sn_valid <= 1'b1;
            o_busy     <= 1'b1;
          end else begin
            o_sn_bit   <= '0;
            o_sn_valid <= 1'b0;
            o_busy     <= 1'b0;
          end
        end
        RUN: begin
          if (i_stop_sng) begin
            state      <= IDLE;
            o_sn_bit   <= '0;
            o_sn_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state      <= DONE;
            cnt        <= '0;
            o_sn_bit   <= '0;
            o_sn_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
          end else begin
            cnt      <= cnt_nxt;
            o_sn_bit <= bit_nxt;
          end
        end
        DONE: begin
          state      <= IDLE;
          o_sn_bit   <= '0;
          o_sn_valid <= 1'b0;
          o_busy     <= 1'b0;
          o_done     <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          o_sn_bit   <= '0;
          o_sn_valid <= 1'b0;
          o_busy     <= 1'b0;
          o_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sng_array.sv
// Directed self-checking bench for sng_array (BW=4, NCH=4).
module tb_sng_array;

  logic        clk;
  logic        rst_n;
  logic [15:0] x_bn;
  logic        start;
  logic        stop;
  logic [3:0]  sn_bit;
  logic        sn_valid;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  sng_array #(.BW(4), .NCH(4), .STRIDE(4)) dut (
    .i_clk_sng   (clk),
    .i_rst_sng   (rst_n),
    .i_x_bn      (x_bn),
    .i_start_sng (start),
    .i_stop_sng  (stop),
    .o_sn_bit    (sn_bit),
    .o_sn_valid  (sn_valid),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_pulse(input logic [15:0] x);
    @(negedge clk);
    x_bn  = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one stream from start; optionally re-requests start with alt data mid-stream.
  task automatic run_stream(input logic [15:0] x, input bit inj, input logic [15:0] alt,
                            output int c0, output int c1, output int c2, output int c3,
                            output int nvalid, output int done_at,
                            output logic [15:0] s0, output logic [15:0] s1);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; nvalid = 0; done_at = 0; s0 = '0; s1 = '0;
    start_pulse(x);
    for (int n = 1; n <= 40; n++) begin
      if (sn_valid) begin
        if (nvalid < 16) begin
          s0[nvalid] = sn_bit[0];
          s1[nvalid] = sn_bit[1];
        end
        c0 += int'(sn_bit[0]);
        c1 += int'(sn_bit[1]);
        c2 += int'(sn_bit[2]);
        c3 += int'(sn_bit[3]);
        nvalid++;
      end
      if (done) begin
        done_at = n;
        break;
      end
      if (inj && n == 4) begin
        x_bn  = alt;
        start = 1'b1;
      end
      if (n == 5) start = 1'b0;
      @(negedge clk);
    end
  endtask

  int c0, c1, c2, c3, nv, dat, seen;
  logic [15:0] s0, s1;

  initial begin
    rst_n = 1'b0;
    x_bn  = '0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_bit",   int'(sn_bit),   0);
    check("rst_valid", int'(sn_valid), 0);
    check("rst_busy",  int'(busy),     0);
    check("rst_done",  int'(done),     0);
    rst_n = 1'b1;

    // x = {15,8,5,0} on ch3..ch0
    run_stream(16'hF850, 1'b0, 16'h0000, c0, c1, c2, c3, nv, dat, s0, s1);
    check("s1_cnt0", c0, 0);
    check("s1_cnt1", c1, 5);
    check("s1_cnt2", c2, 8);
    check("s1_cnt3", c3, 15);
    check("s1_nvalid", nv, 16);
    check("s1_done_at", dat, 17);
    @(negedge clk);
    check("s1_done_pulse", int'(done), 0);
    check("s1_idle_busy", int'(busy), 0);

    // ch0=8, ch1=5, ch2=15, ch3=0; mid-stream start with other data must be ignored
    run_stream(16'h0F58, 1'b1, 16'h1234, c0, c1, c2, c3, nv, dat, s0, s1);
    check("s2_cnt0", c0, 8);
    check("s2_cnt1", c1, 5);
    check("s2_cnt2", c2, 15);
    check("s2_cnt3", c3, 0);
    check("s2_done_at", dat, 17);
    check("s2_seq_ch0", int'(s0), 32'h5555);
`ifndef SNG_DECOR_EN
    check("s2_seq_ch1", int'(s1), 32'h1115);
`endif
    @(negedge clk);

    // abort at RUN cycle 6
    start_pulse(16'h00FF);
    check("st_busy_run", int'(busy), 1);
    repeat (5) @(negedge clk);
    check("st_valid_c6", int'(sn_valid), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("st_valid", int'(sn_valid), 0);
    check("st_bit",   int'(sn_bit),   0);
    check("st_busy",  int'(busy),     0);
    seen = 0;
    repeat (20) begin
      seen |= int'(done);
      @(negedge clk);
    end
    check("st_no_done", seen, 0);
    run_stream(16'h0003, 1'b0, 16'h0000, c0, c1, c2, c3, nv, dat, s0, s1);
    check("st_restart_cnt0", c0, 3);
    check("st_restart_done", dat, 17);
    @(negedge clk);

    // start and stop together in IDLE: stop wins
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("both_busy",  int'(busy),     0);
    check("both_valid", int'(sn_valid), 0);

    // async reset between edges at RUN cycle 3
    start_pulse(16'hFFFF);
    repeat (2) @(negedge clk);
    check("rs_busy_pre", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_bit",   int'(sn_bit),   0);
    check("rs_valid", int'(sn_valid), 0);
    check("rs_busy",  int'(busy),     0);
    check("rs_done",  int'(done),     0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      seen |= int'(done) | int'(sn_valid);
      @(negedge clk);
    end
    check("rs_no_done", seen, 0);
    run_stream(16'h000F, 1'b0, 16'h0000, c0, c1, c2, c3, nv, dat, s0, s1);
    check("rs_cnt0", c0, 15);
    check("rs_cnt1", c1, 0);
    check("rs_done_at", dat, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
